y86_core_param: RTL
===================

Name: y86_core_param

Overview:
- Parametrised multi-cycle successor of the `processor` block: load-then-run core with an internal instruction memory, a register file and condition codes.
- Adds four things over `processor`:
  - configurable data width, register count and instruction-memory depth;
  - a conditional-jump instruction;
  - halt/status reporting;
  - a register readback port instead of fixed r0..r7 outputs.
- Loaded through the same addr/wr/wdata port, then started with `working`; used as the core under test in the processor benches.

Parameters:
- DATA_W, 32: register, ALU and valE width. Must be ≥16.
- NREGS, 8: number of registers. Must be 1..15; register index 4'hF means "none".
- IMEM_AW, 5: instruction memory address width; depth is 2^IMEM_AW words of 32 bits.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  synchronous active-low reset.
- addr  in  IMEM_AW  instruction memory write address.
- wr  in  1  instruction memory write enable. Honoured only in IDLE or HALT.
- wdata  in  32  instruction word to write.
- working  in  1  run request.
- rID  in  4  register readback select.
- rdata  out  DATA_W  combinational value of reg[rID]; 0 when rID ≥ NREGS.
- valE  out  DATA_W  last ALU/move result (registered).
- cc  out  3  {ZF,SF,OF} (registered).
- pc  out  IMEM_AW  current program counter.
- stat  out  2  0=AOK, 1=HLT, 2=INS (illegal instruction).
- busy  out  1  high in FETCH, EXEC and WB.

Behaviour:
- Encoding: [31:28] icode, [27:24] ifun, [23:20] rA, [19:16] rB, [15:0] valC.
  - valC is sign-extended to DATA_W.
  - Jump targets use valC[IMEM_AW-1:0].
- Instructions:
  - icode 0, halt.
  - icode 1, irmovl: reg[rB] <= valC. rA must be F.
  - icode 2, OPl: reg[rB] <= reg[rB] op reg[rA]. ifun 0 add, 1 sub (rB−rA), 2 and, 3 xor.
  - icode 3, rrmovl: reg[rB] <= reg[rA].
  - icode 7, jXX: pc <= target if the condition holds, else pc+1.
- Jump conditions by ifun (S=SF^OF):
  - 0 jmp: always.
  - 1 jle: S|ZF.
  - 2 jl: S.
  - 3 je: ZF.
  - 4 jne: ~ZF.
  - 5 jge: ~S.
  - 6 jg: ~S&~ZF.
- Illegal instruction, giving stat=INS and HALT:
  - any other icode;
  - ifun >3 on OPl, or >6 on jXX;
  - any used register index ≥ NREGS.
- State machine: IDLE, FETCH, EXEC, WB, HALT.
  - IDLE→FETCH when working=1.
  - FETCH: ir <= imem[pc].
  - EXEC:
    - decode and compute valE;
    - update cc (OPl only);
    - evaluate the jump condition;
    - halt/illegal instruction → HALT with stat=HLT or INS.
  - WB:
    - register write;
    - pc update, wrapping modulo 2^IMEM_AW;
    - then FETCH if working=1, else IDLE (pc retained, resumable).
  - Latency: 3 cycles per non-halt instruction.
  - HALT→IDLE when working=0; pc <= 0 and stat <= AOK on that transition.
- Condition codes, set only by OPl:
  - ZF = (valE==0); SF = valE[DATA_W-1].
  - add: OF = signed overflow.
  - sub: OF = (rB[msb]≠rA[msb]) & (valE[msb]≠rB[msb]).
  - and/xor: OF = 0.
  - irmovl, rrmovl and jXX leave cc unchanged.
- Imem writes:
  - wr outside IDLE/HALT is ignored.
  - Writes take effect on the clock edge; the memory is not cleared by reset.
- Register file:
  - cleared to 0 by reset;
  - one write per instruction, in WB;
  - rdata shows the new value the cycle after WB.
- Reset (reset_n=0 at the edge), from any state including mid-instruction, forces:
  - state=IDLE, pc=0, valE=0, cc=3'b000, stat=AOK, busy=0, ir=0;
  - all registers 0;
  - the in-flight instruction is discarded with no register write.
- Simultaneous working=1 and wr in IDLE: the write completes and the state moves to FETCH on the same edge, so a write to the current pc is fetched on the next cycle.

Test Plan:
- Baseline program, DATA_W=32:
  - load imem 0..7 with 10F00080..10F70087, then 20010000, 21230000, 22450000, 23670000, 00000000 at 0..12;
  - then working=1;
  - required: r0..r7 = 80, 101, 82, 1, 84, 84, 86, 1 (hex); stat=HLT; pc=12; cc=000;
  - HALT reached exactly 38 cycles after FETCH entry.
- Overflow, DATA_W=16:
  - program: irmovl r0,0x7FFF; add r0,r0; halt;
  - required: r0=0xFFFE, cc={0,1,1};
  - then sub r0,r0 gives r0=0 and cc={1,0,0}.
- Loop:
  - program: irmovl r1,3; irmovl r2,1; sub r2,r1; jne 2; halt;
  - required: r1=0; 3 taken-not/taken sequence (jne taken twice, then falls through); halt at pc=4; ZF=1.
- Pause/resume and wrap:
  - drop working mid-EXEC → state IDLE after WB, pc retained;
  - writes accepted while paused; reassert → execution resumes at the same pc;
  - jmp at the top address wraps correctly.
- Illegal instruction:
  - program word 0x2F010000 (OPl with ifun F), and separately rB=9 with NREGS=8;
  - required: stat=INS, no register or cc change, state HALT.
- Reset mid-run:
  - pulse reset_n=0 one cycle during WB of an add;
  - required: target register stays 0; pc=0; valE=0; cc=0; stat=AOK; state IDLE;
  - imem contents preserved, and rerun yields the baseline results.

Source files
------------

// File: rtl/y86_core_param_if.sv
// Load/run/readback bus of y86_core_param: imem write port, run request,
// register readback and architectural status.
interface y86_core_param_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned IMEM_AW = 5
);
  logic [IMEM_AW-1:0] addr;
  logic               wr;
  logic [31:0]        wdata;
  logic               working;
  logic [3:0]         rID;
  logic [DATA_W-1:0]  rdata;
  logic [DATA_W-1:0]  valE;
  logic [2:0]         cc;
  logic [IMEM_AW-1:0] pc;
  logic [1:0]         stat;
  logic               busy;

  modport master (
    output addr, wr, wdata, working, rID,
    input  rdata, valE, cc, pc, stat, busy
  );

  modport slave (
    input  addr, wr, wdata, working, rID,
    output rdata, valE, cc, pc, stat, busy
  );
endinterface

// File: rtl/y86_core_param.sv
// Parametrised multi-cycle Y86 subset core: load imem while idle, then run
// FETCH -> EXEC -> WB per instruction until halt or an illegal instruction.
module y86_core_param #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NREGS   = 8,
  parameter int unsigned IMEM_AW = 5
) (
  input logic             clock,
  input logic             reset_n,
  y86_core_param_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_WB, S_HALT} state_t;
  typedef enum logic [1:0] {ST_AOK = 2'd0, ST_HLT = 2'd1, ST_INS = 2'd2} stat_t;

  localparam logic [3:0] NREGS_L = 4'(NREGS);

  state_t             state, state_nx;
  stat_t              stat;
  logic [31:0]        imem [2**IMEM_AW];
  logic [31:0]        ir;
  logic [IMEM_AW-1:0] pc, pc_nx;
  logic [DATA_W-1:0]  regs [NREGS];
  logic [DATA_W-1:0]  vale, vala, valb, alu, valc_x, rdata;
  logic [2:0]         cc;
  logic               wen, of, cond, illegal, s_flag;

  logic [3:0]  icode, ifun, ra, rb;
  logic [15:0] valc;

  assign icode  = ir[31:28];
  assign ifun   = ir[27:24];
  assign ra     = ir[23:20];
  assign rb     = ir[19:16];
  assign valc   = ir[15:0];
  assign valc_x = DATA_W'($signed(valc));
  assign s_flag = cc[1] ^ cc[0];

  // Register read muxes for both operands and the readback port
  always_comb begin
    vala  = '0;
    valb  = '0;
    rdata = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (ra == 4'(i))      vala  = regs[i];
      if (rb == 4'(i))      valb  = regs[i];
      if (bus.rID == 4'(i)) rdata = regs[i];
    end
  end

  // ALU: result is valB op valA; OF rule depends on the operation
  always_comb begin
    alu = '0;
    of  = 1'b0;
    case (ifun[1:0])
      2'd0: begin
        alu = valb + vala;
        of  = (valb[DATA_W-1] == vala[DATA_W-1]) && (alu[DATA_W-1] != valb[DATA_W-1]);
      end
      2'd1: begin
        alu = valb - vala;
        of  = (valb[DATA_W-1] != vala[DATA_W-1]) && (alu[DATA_W-1] != valb[DATA_W-1]);
      end
      2'd2:    alu = valb & vala;
      default: alu = valb ^ vala;
    endcase
  end

  // Jump condition from the current condition codes
  always_comb begin
    cond = 1'b0;
    case (ifun)
      4'd0:    cond = 1'b1;
      4'd1:    cond = s_flag | cc[2];
      4'd2:    cond = s_flag;
      4'd3:    cond = cc[2];
      4'd4:    cond = ~cc[2];
      4'd5:    cond = ~s_flag;
      4'd6:    cond = ~s_flag & ~cc[2];
      default: cond = 1'b0;
    endcase
  end

  // Illegal-instruction detection: unknown icode/ifun or out-of-range register
  always_comb begin
    illegal = 1'b0;
    case (icode)
      4'h0:    illegal = 1'b0;
      4'h1:    illegal = (ra != 4'hF) || (rb >= NREGS_L);
      4'h2:    illegal = (ifun > 4'd3) || (ra >= NREGS_L) || (rb >= NREGS_L);
      4'h3:    illegal = (ra >= NREGS_L) || (rb >= NREGS_L);
      4'h7:    illegal = (ifun > 4'd6);
      default: illegal = 1'b1;
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (bus.working) state_nx = S_FETCH;
      S_FETCH: state_nx = S_EXEC;
      S_EXEC:  state_nx = (illegal || icode == 4'h0) ? S_HALT : S_WB;
      S_WB:    state_nx = bus.working ? S_FETCH : S_IDLE;
      S_HALT:  if (!bus.working) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Instruction memory write port; contents survive reset
  always_ff @(posedge clock) begin
    if ((state == S_IDLE || state == S_HALT) && bus.wr) imem[bus.addr] <= bus.wdata;
  end

  // Datapath: fetch, execute into valE/cc/next pc, write back in WB
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pc    <= '0;
      pc_nx <= '0;
      ir    <= '0;
      vale  <= '0;
      cc    <= '0;
      stat  <= ST_AOK;
      wen   <= 1'b0;
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_FETCH: ir <= imem[pc];
        S_EXEC: begin
          if (illegal)               stat <= ST_INS;
          else if (icode == 4'h0)    stat <= ST_HLT;
          else begin
            wen   <= (icode != 4'h7);
            pc_nx <= (icode == 4'h7 && cond) ? valc[IMEM_AW-1:0] : pc + IMEM_AW'(1);
            case (icode)
              4'h1: vale <= valc_x;
              4'h2: begin
                vale <= alu;
                cc   <= {alu == '0, alu[DATA_W-1], of};
              end
              4'h3: vale <= vala;
              default: ;
            endcase
          end
        end
        S_WB: begin
          for (int unsigned i = 0; i < NREGS; i++)
            if (wen && rb == 4'(i)) regs[i] <= vale;
          pc <= pc_nx;
        end
        S_HALT: if (!bus.working) begin
          pc   <= '0;
          stat <= ST_AOK;
        end
        default: ;
      endcase
    end
  end

  assign bus.rdata = rdata;
  assign bus.valE  = vale;
  assign bus.cc    = cc;
  assign bus.pc    = pc;
  assign bus.stat  = stat;
  assign bus.busy  = (state == S_FETCH) || (state == S_EXEC) || (state == S_WB);
endmodule
